// File: rtl/data_mem_pipe.sv
// RV32I load/store data memory behind a valid/ready handshake, with configurable latency.
// Define DATA_MEM_MISALIGN_SPLIT_EN to split misaligned half/word accesses into two word accesses.
module data_mem_pipe #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_val,
    output logic              rsp_valid,
    output logic [31:0]       read_val,
    output logic              rsp_err
);

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam int WIDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << WIDX_W;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_e;

    state_e              state_q;
    logic [2:0]          cnt_q;
    logic                write_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wval_q;
    logic [31:0]         lo_q;
    logic                ready_q;
    logic                rsp_valid_q;
    logic [31:0]         read_val_q;
    logic                rsp_err_q;
    logic [31:0]         mem_q [DEPTH];

    logic [WIDX_W-1:0]   widx;
    logic [WIDX_W-1:0]   widx_nxt;
    logic [1:0]          off;
    logic                illegal;
    logic                misaligned;
    logic                err;
    logic                do_split;
    logic [3:0]          lane_mask;
    logic [7:0]          be_d;
    logic [63:0]         wdata_d;
    logic [63:0]         rdata64;
    logic [31:0]         rsh;
    logic [31:0]         read_val_d;
    logic                final_cyc;
    logic                wr_lo;
    logic                wr_hi;

    assign widx     = addr_q[ADDR_W-1:2];
    assign widx_nxt = widx + WIDX_W'(1);
    assign off      = addr_q[1:0];

    always_comb begin
        illegal = 1'b1;
        case (f3_q)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = write_q;
            default:                illegal = 1'b1;
        endcase
    end

    assign misaligned = ((f3_q[1:0] == 2'b01) && off[0]) ||
                        ((f3_q[1:0] == 2'b10) && (off != 2'b00));
    assign err        = illegal || (misaligned && !SPLIT_EN);
    assign do_split   = !illegal && misaligned && SPLIT_EN;

    // Lanes and data are laid out over a 64-bit window: low word at widx, high word at widx+1.
    assign lane_mask = (f3_q[1:0] == 2'b00) ? 4'b0001 :
                       (f3_q[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign be_d      = {4'b0000, lane_mask} << off;
    assign wdata_d   = {32'h0, wval_q} << {off, 3'b000};

    assign rdata64 = {mem_q[widx_nxt], (state_q == SPLIT) ? lo_q : mem_q[widx]};
    assign rsh     = 32'(rdata64 >> {off, 3'b000});

    always_comb begin
        read_val_d = 32'h0;
        case (f3_q)
            3'b000:  read_val_d = {{24{rsh[7]}}, rsh[7:0]};
            3'b001:  read_val_d = {{16{rsh[15]}}, rsh[15:0]};
            3'b010:  read_val_d = rsh;
            3'b100:  read_val_d = {24'h0, rsh[7:0]};
            3'b101:  read_val_d = {16'h0, rsh[15:0]};
            default: read_val_d = 32'h0;
        endcase
    end

    assign final_cyc = (cnt_q == 3'd0);
    assign wr_lo = !reset && (state_q == ACCESS) && final_cyc && write_q && !err;
    assign wr_hi = !reset && (state_q == SPLIT) && final_cyc && write_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_lo && be_d[b]) mem_q[widx][8*b +: 8] <= wdata_d[8*b +: 8];
            if (wr_hi && be_d[4+b]) mem_q[widx_nxt][8*b +: 8] <= wdata_d[32+8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            read_val_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        wval_q  <= write_val;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!final_cyc) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else if (do_split) begin
                        lo_q    <= mem_q[widx];
                        cnt_q   <= CNT_INIT;
                        state_q <= SPLIT;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err;
                        read_val_q  <= (write_q || err) ? 32'h0 : read_val_d;
                        state_q     <= RESP;
                    end
                end
                SPLIT: begin
                    if (!final_cyc) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        read_val_q  <= write_q ? 32'h0 : read_val_d;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign read_val  = read_val_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: directed vector table, reset corner cases, and random traffic
// checked against a byte-array model of the memory.
module tb_data_mem_pipe;

    localparam int LAT  = 2;
    localparam int LAT4 = 4;
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, valid0, valid1;
    logic        req_write;
    logic [2:0]  funct3;
    logic [7:0]  addr;
    logic [31:0] write_val;
    logic        rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;

    data_mem_pipe #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset(rst0), .req_valid(valid0), .req_ready(rdy0),
        .req_write(req_write), .funct3(funct3), .addr(addr), .write_val(write_val),
        .rsp_valid(rv0), .read_val(rd0), .rsp_err(er0));

    data_mem_pipe #(.ADDR_W(8), .LATENCY(LAT4)) dut4 (
        .clk(clk), .reset(rst1), .req_valid(valid1), .req_ready(rdy1),
        .req_write(req_write), .funct3(funct3), .addr(addr), .write_val(write_val),
        .rsp_valid(rv1), .read_val(rd1), .rsp_err(er1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One full transaction on the selected instance; returns response and handshake sanity flag.
    task automatic txn(input int which, input logic w, input logic [2:0] f, input logic [7:0] a,
                       input logic [31:0] wv, output logic [31:0] rv, output logic er,
                       output int lat, output bit hs_ok);
        hs_ok = ((which == 0) ? rdy0 : rdy1) === 1'b1;
        req_write = w; funct3 = f; addr = a; write_val = wv;
        if (which == 0) valid0 = 1'b1; else valid1 = 1'b1;
        @(posedge clk); #1;
        valid0 = 1'b0; valid1 = 1'b0;
        lat = 0; rv = 32'h0; er = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (((which == 0) ? rdy0 : rdy1) !== 1'b0) hs_ok = 1'b0;
            if (((which == 0) ? rv0 : rv1) === 1'b1) begin
                lat = i - 1;
                rv  = (which == 0) ? rd0 : rd1;
                er  = (which == 0) ? er0 : er1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (((which == 0) ? rv0 : rv1) !== 1'b0) hs_ok = 1'b0;
        if (((which == 0) ? rdy0 : rdy1) !== 1'b1) hs_ok = 1'b0;
    endtask

    logic [7:0] mb [256];

    task automatic model(input logic w, input logic [2:0] f, input logic [7:0] a,
                         input logic [31:0] wv, output logic [31:0] rv, output logic er,
                         output int lat);
        bit ill, mis;
        int sz;
        logic [31:0] u;
        ill = (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (w && f >= 3'd4);
        sz  = 1 << f[1:0];
        mis = (int'(a) % sz) != 0;
        lat = LAT; rv = 32'h0; er = 1'b0;
        if (ill || (mis && !SPLIT)) begin
            er = 1'b1;
            return;
        end
        if (mis) lat = 2 * LAT;
        if (w) begin
            for (int k = 0; k < sz; k++) mb[(int'(a) + k) % 256] = wv[8*k +: 8];
        end else begin
            u = 32'h0;
            for (int k = 0; k < sz; k++) u = u | (32'(mb[(int'(a) + k) % 256]) << (8 * k));
            if (!f[2] && sz < 4 && u[8*sz-1]) u = u - (32'h1 << (8 * sz));
            rv = u;
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f;
        logic [7:0]  a;
        logic [31:0] wv;
        logic [31:0] erv;
        logic        eer;
        int          elat;
    } vec_t;

    vec_t tv[$];

    initial begin
        logic [31:0] rv, mrv;
        logic er, mer;
        int lat, mlat;
        bit hs, seen;

        rst0 = 1'b1; rst1 = 1'b1; valid0 = 1'b0; valid1 = 1'b0;
        req_write = 1'b0; funct3 = 3'd0; addr = 8'h0; write_val = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        chk("reset_ready", 32'(rdy0), 32'h1);
        chk("reset_rsp_valid", 32'(rv0), 32'h0);
        chk("reset_read_val", rd0, 32'h0);
        chk("reset_rsp_err", 32'(er0), 32'h0);

        tv.push_back('{1'b1, 3'b000, 8'hF0, 32'd453, 32'h0, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b000, 8'hF0, 32'h0, 32'hFFFFFFC5, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b100, 8'hF0, 32'h0, 32'h000000C5, 1'b0, LAT});
        tv.push_back('{1'b1, 3'b001, 8'h04, 32'd345, 32'h0, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b001, 8'h04, 32'h0, 32'h00000159, 1'b0, LAT});
        tv.push_back('{1'b1, 3'b010, 8'h00, 32'd247, 32'h0, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b010, 8'h00, 32'h0, 32'd247, 1'b0, LAT});
        tv.push_back('{1'b1, 3'b001, 8'h06, 32'h00008001, 32'h0, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b001, 8'h06, 32'h0, 32'hFFFF8001, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b101, 8'h06, 32'h0, 32'h00008001, 1'b0, LAT});
        tv.push_back('{1'b1, 3'b010, 8'h00, 32'h11223344, 32'h0, 1'b0, LAT});
        tv.push_back('{1'b1, 3'b010, 8'h04, 32'h55667788, 32'h0, 1'b0, LAT});
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
        tv.push_back('{1'b0, 3'b010, 8'h02, 32'h0, 32'h77881122, 1'b0, 2*LAT});
`else
        tv.push_back('{1'b0, 3'b010, 8'h02, 32'h0, 32'h0, 1'b1, LAT});
`endif
        tv.push_back('{1'b0, 3'b010, 8'h04, 32'h0, 32'h55667788, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b011, 8'h00, 32'h0, 32'h0, 1'b1, LAT});
        tv.push_back('{1'b1, 3'b100, 8'h00, 32'hFFFFFFFF, 32'h0, 1'b1, LAT});
        tv.push_back('{1'b0, 3'b010, 8'h00, 32'h0, 32'h11223344, 1'b0, LAT});
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
        tv.push_back('{1'b1, 3'b010, 8'hFE, 32'hAABBCCDD, 32'h0, 1'b0, 2*LAT});
        tv.push_back('{1'b0, 3'b010, 8'hFE, 32'h0, 32'hAABBCCDD, 1'b0, 2*LAT});
        tv.push_back('{1'b0, 3'b010, 8'h00, 32'h0, 32'h1122AABB, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b100, 8'hFF, 32'h0, 32'h000000CC, 1'b0, LAT});
`else
        tv.push_back('{1'b1, 3'b010, 8'hFE, 32'hAABBCCDD, 32'h0, 1'b1, LAT});
        tv.push_back('{1'b0, 3'b001, 8'h05, 32'h0, 32'h0, 1'b1, LAT});
        tv.push_back('{1'b0, 3'b010, 8'h00, 32'h0, 32'h11223344, 1'b0, LAT});
        tv.push_back('{1'b0, 3'b101, 8'h00, 32'h0, 32'h00003344, 1'b0, LAT});
`endif

        for (int i = 0; i < tv.size(); i++) begin
            txn(0, tv[i].w, tv[i].f, tv[i].a, tv[i].wv, rv, er, lat, hs);
            chk($sformatf("vec%0d_read_val", i), rv, tv[i].erv);
            chk($sformatf("vec%0d_rsp_err", i), 32'(er), 32'(tv[i].eer));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].elat));
            chk($sformatf("vec%0d_handshake", i), 32'(hs), 32'h1);
        end

        // Reset together with a request: nothing may be accepted.
        req_write = 1'b0; funct3 = 3'b010; addr = 8'h00;
        rst0 = 1'b1; valid0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0; valid0 = 1'b0;
        chk("rst_req_ready", 32'(rdy0), 32'h1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rv0 !== 1'b0 || rdy0 !== 1'b1) seen = 1'b1;
        end
        chk("rst_req_no_accept", 32'(seen), 32'h0);

        // Reset one cycle into a load on the LATENCY=4 instance.
        txn(1, 1'b1, 3'b010, 8'h08, 32'hCAFEF00D, rv, er, lat, hs);
        chk("l4_sw_latency", 32'(lat), 32'(LAT4));
        req_write = 1'b0; funct3 = 3'b010; addr = 8'h08;
        valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("l4_ready_after_reset", 32'(rdy1), 32'h1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rv1 !== 1'b0) seen = 1'b1;
        end
        chk("l4_no_response", 32'(seen), 32'h0);
        txn(1, 1'b0, 3'b010, 8'h08, 32'h0, rv, er, lat, hs);
        chk("l4_lw_read_val", rv, 32'hCAFEF00D);
        chk("l4_lw_latency", 32'(lat), 32'(LAT4));
        chk("l4_lw_handshake", 32'(hs), 32'h1);

        // Random traffic against the byte-array model, after giving every word a known value.
        for (int wi = 0; wi < 64; wi++) begin
            logic [31:0] v;
            v = $urandom;
            model(1'b1, 3'b010, 8'(wi * 4), v, mrv, mer, mlat);
            txn(0, 1'b1, 3'b010, 8'(wi * 4), v, rv, er, lat, hs);
        end
        for (int n = 0; n < 300; n++) begin
            logic        w;
            logic [2:0]  f;
            logic [7:0]  a;
            logic [31:0] v;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = 8'($urandom_range(0, 255));
            v = $urandom;
            model(w, f, a, v, mrv, mer, mlat);
            txn(0, w, f, a, v, rv, er, lat, hs);
            chk($sformatf("rnd%0d_read_val", n), rv, mrv);
            chk($sformatf("rnd%0d_rsp_err", n), 32'(er), 32'(mer));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d_handshake", n), 32'(hs), 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
